// File: rtl/baseline_sched_if.sv
// Bundle of ADC sample inputs, re-measure requests and published baselines
// exchanged between the baseline scheduler and its neighbours.
interface baseline_sched_if;
  logic [13:0] adc0;
  logic [13:0] adc1;
  logic        req0;
  logic        req1;
  logic [13:0] baseline0;
  logic [13:0] baseline1;
  logic        valid0;
  logic        valid1;
  logic        update;
  logic        sel;
  logic        busy;

  modport master (
    output adc0, adc1, req0, req1,
    input  baseline0, baseline1, valid0, valid1, update, sel, busy
  );

  modport slave (
    input  adc0, adc1, req0, req1,
    output baseline0, baseline1, valid0, valid1, update, sel, busy
  );
endinterface

// File: rtl/baseline_sched.sv
// Shares one accumulator between two ADC channels to measure and refresh
// each channel's baseline after power-up, periodically and on request.
module baseline_sched #(
  parameter int INITWAIT = 1000000,
  parameter int LOG2_WIN = 7,
  parameter int PERIOD   = 16000000
) (
  input logic             clk,
  input logic             rst,
  baseline_sched_if.slave bus
);
  localparam logic [1:0] S_INIT  = 2'd0;
  localparam logic [1:0] S_IDLE  = 2'd1;
  localparam logic [1:0] S_ACC   = 2'd2;
  localparam logic [1:0] S_STORE = 2'd3;

  localparam logic [31:0]         INIT_LAST = 32'(INITWAIT);
  localparam logic [31:0]         PER_LAST  = 32'(PERIOD - 1);
  localparam bit                  PER_EN    = (PERIOD != 0);
  localparam logic [LOG2_WIN-1:0] SMP_ONE   = LOG2_WIN'(1);

  logic [1:0]          state_q, state_d;
  logic [31:0]         init_cnt_q, init_cnt_d;
  logic [31:0]         tmr_q, tmr_d;
  logic [LOG2_WIN-1:0] smp_cnt_q, smp_cnt_d;
  logic [23:0]         sum_q, sum_d;
  logic                pend0_q, pend0_d, pend1_q, pend1_d;
  logic                last_q, last_d;
  logic                sel_q, sel_d;
  logic [13:0]         base0_q, base0_d, base1_q, base1_d;
  logic                valid0_q, valid0_d, valid1_q, valid1_d;
  logic                update_q, update_d;
  logic                busy_q, busy_d;

  logic        grant0, grant1, grant_ch, init_exit, per_hit;
  logic [13:0] adc_sel;

  assign adc_sel  = sel_q ? bus.adc1 : bus.adc0;
  // With both pending the channel not served last wins.
  assign grant_ch = (pend0_q && pend1_q) ? ~last_q : pend1_q;

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    tmr_d      = tmr_q;
    smp_cnt_d  = smp_cnt_q;
    sum_d      = sum_q;
    last_d     = last_q;
    sel_d      = sel_q;
    base0_d    = base0_q;
    base1_d    = base1_q;
    valid0_d   = valid0_q;
    valid1_d   = valid1_q;
    update_d   = 1'b0;
    grant0     = 1'b0;
    grant1     = 1'b0;
    init_exit  = 1'b0;
    per_hit    = 1'b0;

    case (state_q)
      S_INIT: begin
        if (init_cnt_q == INIT_LAST) begin
          init_exit = 1'b1;
          state_d   = S_IDLE;
        end else begin
          init_cnt_d = init_cnt_q + 32'd1;
        end
      end
      S_IDLE: begin
        if (pend0_q || pend1_q) begin
          grant0    = ~grant_ch;
          grant1    = grant_ch;
          last_d    = grant_ch;
          sel_d     = grant_ch;
          sum_d     = 24'd0;
          smp_cnt_d = '0;
          state_d   = S_ACC;
        end
      end
      S_ACC: begin
        sum_d     = sum_q + {10'd0, adc_sel};
        smp_cnt_d = smp_cnt_q + SMP_ONE;
        if (&smp_cnt_q) begin
          state_d = S_STORE;
        end
      end
      default: begin
        if (sel_q) begin
          base1_d  = sum_q[LOG2_WIN+13:LOG2_WIN];
          valid1_d = 1'b1;
        end else begin
          base0_d  = sum_q[LOG2_WIN+13:LOG2_WIN];
          valid0_d = 1'b1;
        end
        update_d = 1'b1;
        state_d  = S_IDLE;
      end
    endcase

    // Period timer runs freely outside INIT; it restarts from 0 on INIT exit.
    if (PER_EN && (state_q != S_INIT)) begin
      if (tmr_q == PER_LAST) begin
        tmr_d   = 32'd0;
        per_hit = 1'b1;
      end else begin
        tmr_d = tmr_q + 32'd1;
      end
    end

    // A set beats a same-cycle grant clear, so a request during its own
    // window schedules one more measurement.
    pend0_d = ((state_q != S_INIT) && bus.req0) || per_hit || init_exit || (pend0_q && !grant0);
    pend1_d = ((state_q != S_INIT) && bus.req1) || per_hit || init_exit || (pend1_q && !grant1);
    busy_d  = (state_d == S_ACC) || (state_d == S_STORE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_INIT;
      init_cnt_q <= 32'd0;
      tmr_q      <= 32'd0;
      smp_cnt_q  <= '0;
      sum_q      <= 24'd0;
      pend0_q    <= 1'b0;
      pend1_q    <= 1'b0;
      last_q     <= 1'b1;
      sel_q      <= 1'b0;
      base0_q    <= 14'd0;
      base1_q    <= 14'd0;
      valid0_q   <= 1'b0;
      valid1_q   <= 1'b0;
      update_q   <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      tmr_q      <= tmr_d;
      smp_cnt_q  <= smp_cnt_d;
      sum_q      <= sum_d;
      pend0_q    <= pend0_d;
      pend1_q    <= pend1_d;
      last_q     <= last_d;
      sel_q      <= sel_d;
      base0_q    <= base0_d;
      base1_q    <= base1_d;
      valid0_q   <= valid0_d;
      valid1_q   <= valid1_d;
      update_q   <= update_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.baseline0 = base0_q;
  assign bus.baseline1 = base1_q;
  assign bus.valid0    = valid0_q;
  assign bus.valid1    = valid1_q;
  assign bus.update    = update_q;
  assign bus.sel       = sel_q;
  assign bus.busy      = busy_q;
endmodule

// File: tb/tb_baseline_sched.sv
// Scoreboard bench for baseline_sched: expected stores are queued with their
// due cycle and matched against observed update pulses.
module tb_baseline_sched;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [13:0] adc0 = 14'd0;
  logic [13:0] adc1 = 14'd0;
  logic        req0 = 1'b0;
  logic        req1 = 1'b0;

  always #5 clk = ~clk;

  baseline_sched_if bus ();
  baseline_sched_if bus_p ();

  assign bus.adc0   = adc0;
  assign bus.adc1   = adc1;
  assign bus.req0   = req0;
  assign bus.req1   = req1;
  assign bus_p.adc0 = adc0;
  assign bus_p.adc1 = adc1;
  assign bus_p.req0 = 1'b0;
  assign bus_p.req1 = 1'b0;

  baseline_sched #(.INITWAIT(20), .LOG2_WIN(3), .PERIOD(0)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  baseline_sched #(.INITWAIT(20), .LOG2_WIN(3), .PERIOD(100)) dut_p (
    .clk(clk), .rst(rst), .bus(bus_p)
  );

  typedef struct {
    int ch;
    int val;
    int at;
  } ev_t;

  ev_t exp_q[$];
  ev_t obs_q[$];
  int  checks   = 0;
  int  failures = 0;
  int  cyc      = 0;
  int  rel0     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Index of the most recent rising edge, counted from reset release (edge 0).
  function automatic int edge_idx();
    return cyc - rel0 - 1;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst  = 1'b1;
    req0 = 1'b0;
    req1 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst  = 1'b0;
    rel0 = cyc;
  endtask

  task automatic pulse(input bit a, input bit b, output int t);
    @(negedge clk);
    req0 = a;
    req1 = b;
    t    = edge_idx() + 1;
    @(negedge clk);
    req0 = 1'b0;
    req1 = 1'b0;
  endtask

  // Records every update pulse of the selected instance for ncyc cycles.
  task automatic collect(input bit use_p, input int ncyc);
    ev_t ev;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      if (use_p ? bus_p.update : bus.update) begin
        ev.ch  = use_p ? int'(bus_p.sel) : int'(bus.sel);
        ev.val = use_p ? (bus_p.sel ? int'(bus_p.baseline1) : int'(bus_p.baseline0))
                       : (bus.sel ? int'(bus.baseline1) : int'(bus.baseline0));
        ev.at  = edge_idx();
        obs_q.push_back(ev);
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({bus.baseline0, bus.baseline1, bus.valid0, bus.valid1, bus.update, bus.busy, bus.sel} !== 33'd0) begin
      failures++;
      $display("FAIL reset_outputs got b0=%0d b1=%0d v0=%b v1=%b upd=%b busy=%b sel=%b want all 0",
               bus.baseline0, bus.baseline1, bus.valid0, bus.valid1, bus.update, bus.busy, bus.sel);
    end
    checks++;
    if ({bus_p.baseline0, bus_p.baseline1, bus_p.valid0, bus_p.valid1, bus_p.update, bus_p.busy, bus_p.sel} !== 33'd0) begin
      failures++;
      $display("FAIL reset_outputs_p got nonzero outputs, want all 0");
    end
    $display("test_reset done");
  endtask

  task automatic test_powerup();
    ev_t e, o, ev;
    adc0 = 14'd1000;
    adc1 = 14'd3000;
    do_reset();
    exp_q.push_back('{0, 1000, 30});
    exp_q.push_back('{1, 3000, 40});
    for (int k = 0; k < 45; k++) begin
      @(negedge clk);
      if (edge_idx() == 20) begin
        checks++;
        if (bus.busy !== 1'b0) begin failures++; $display("FAIL powerup_busy20 got=%b want=0", bus.busy); end
      end
      if (edge_idx() == 21) begin
        checks++;
        if (bus.busy !== 1'b1) begin failures++; $display("FAIL powerup_busy21 got=%b want=1", bus.busy); end
      end
      if (edge_idx() == 29) begin
        checks++;
        if (bus.valid0 !== 1'b0) begin failures++; $display("FAIL powerup_valid0_early got=%b want=0", bus.valid0); end
      end
      if (bus.update) begin
        ev.ch  = int'(bus.sel);
        ev.val = bus.sel ? int'(bus.baseline1) : int'(bus.baseline0);
        ev.at  = edge_idx();
        obs_q.push_back(ev);
      end
    end
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL powerup_count got=%0d want=%0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o.ch != e.ch || o.val != e.val || o.at != e.at) begin
        failures++;
        $display("FAIL powerup_store got ch=%0d val=%0d at=%0d want ch=%0d val=%0d at=%0d", o.ch, o.val, o.at, e.ch, e.val, e.at);
      end
    end
    checks++;
    if ({bus.valid0, bus.valid1} !== 2'b11) begin
      failures++;
      $display("FAIL powerup_valids got=%b%b want=11", bus.valid0, bus.valid1);
    end
    exp_q.delete();
    obs_q.delete();
    $display("test_powerup done");
  endtask

  task automatic test_average();
    ev_t e, o;
    int  t;
    // Ramp 1..8 lands exactly in the channel 0 window (edges t+2..t+9).
    pulse(1'b1, 1'b0, t);
    @(negedge clk);
    adc0 = 14'd1;
    for (int v = 2; v <= 8; v++) begin
      @(negedge clk);
      adc0 = 14'(v);
    end
    @(negedge clk);
    adc0 = 14'd9000;
    exp_q.push_back('{0, 4, t + 10});
    collect(1'b0, 3);
    adc0 = 14'd16383;
    adc1 = 14'd16383;
    pulse(1'b0, 1'b1, t);
    exp_q.push_back('{1, 16383, t + 10});
    collect(1'b0, 12);
    pulse(1'b1, 1'b0, t);
    exp_q.push_back('{0, 16383, t + 10});
    collect(1'b0, 12);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL average_count got=%0d want=%0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o.ch != e.ch || o.val != e.val || o.at != e.at) begin
        failures++;
        $display("FAIL average_store got ch=%0d val=%0d at=%0d want ch=%0d val=%0d at=%0d", o.ch, o.val, o.at, e.ch, e.val, e.at);
      end
    end
    exp_q.delete();
    obs_q.delete();
    $display("test_average done");
  endtask

  task automatic test_arbitration();
    ev_t e, o;
    int  t;
    adc0 = 14'd111;
    adc1 = 14'd222;
    pulse(1'b1, 1'b1, t);
    exp_q.push_back('{1, 222, t + 10});
    exp_q.push_back('{0, 111, t + 20});
    collect(1'b0, 30);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL arbitration_count got=%0d want=%0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o.ch != e.ch || o.val != e.val || o.at != e.at) begin
        failures++;
        $display("FAIL arbitration_store got ch=%0d val=%0d at=%0d want ch=%0d val=%0d at=%0d", o.ch, o.val, o.at, e.ch, e.val, e.at);
      end
    end
    exp_q.delete();
    obs_q.delete();
    $display("test_arbitration done");
  endtask

  task automatic test_req_during_acc();
    ev_t e, o;
    int  t, t2;
    adc0 = 14'd50;
    // Single extra request mid-window.
    pulse(1'b1, 1'b0, t);
    repeat (2) @(negedge clk);
    pulse(1'b1, 1'b0, t2);
    exp_q.push_back('{0, 50, t + 10});
    exp_q.push_back('{0, 50, t + 20});
    collect(1'b0, 31);
    // Three requests in one window collapse into one extra measurement.
    pulse(1'b1, 1'b0, t);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) pulse(1'b1, 1'b0, t2);
    exp_q.push_back('{0, 50, t + 10});
    exp_q.push_back('{0, 50, t + 20});
    collect(1'b0, 30);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL req_during_acc_count got=%0d want=%0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o.ch != e.ch || o.val != e.val || o.at != e.at) begin
        failures++;
        $display("FAIL req_during_acc_store got ch=%0d val=%0d at=%0d want ch=%0d val=%0d at=%0d", o.ch, o.val, o.at, e.ch, e.val, e.at);
      end
    end
    exp_q.delete();
    obs_q.delete();
    $display("test_req_during_acc done");
  endtask

  task automatic test_periodic();
    ev_t e, o;
    adc0 = 14'd1000;
    adc1 = 14'd3000;
    do_reset();
    exp_q.push_back('{0, 1000, 30});
    exp_q.push_back('{1, 3000, 40});
    exp_q.push_back('{0, 1000, 130});
    exp_q.push_back('{1, 3000, 140});
    exp_q.push_back('{0, 1000, 230});
    exp_q.push_back('{1, 500, 240});
    collect(1'b1, 150);
    adc1 = 14'd500;
    collect(1'b1, 100);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL periodic_count got=%0d want=%0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o.ch != e.ch || o.val != e.val || o.at != e.at) begin
        failures++;
        $display("FAIL periodic_store got ch=%0d val=%0d at=%0d want ch=%0d val=%0d at=%0d", o.ch, o.val, o.at, e.ch, e.val, e.at);
      end
    end
    exp_q.delete();
    obs_q.delete();
    $display("test_periodic done");
  endtask

  task automatic test_reset_mid_acc();
    ev_t e, o;
    adc0 = 14'd1000;
    adc1 = 14'd3000;
    do_reset();
    // Channel 1 accumulates on edges 32..39; reset lands on edge 35.
    repeat (35) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.baseline0, bus.baseline1, bus.valid0, bus.valid1, bus.busy, bus.update} !== 32'd0) begin
      failures++;
      $display("FAIL reset_mid_acc_outputs got b0=%0d b1=%0d v0=%b v1=%b busy=%b upd=%b want all 0",
               bus.baseline0, bus.baseline1, bus.valid0, bus.valid1, bus.busy, bus.update);
    end
    rst  = 1'b0;
    rel0 = cyc;
    exp_q.push_back('{0, 1000, 30});
    exp_q.push_back('{1, 3000, 40});
    collect(1'b0, 45);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL reset_mid_acc_count got=%0d want=%0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o.ch != e.ch || o.val != e.val || o.at != e.at) begin
        failures++;
        $display("FAIL reset_mid_acc_store got ch=%0d val=%0d at=%0d want ch=%0d val=%0d at=%0d", o.ch, o.val, o.at, e.ch, e.val, e.at);
      end
    end
    exp_q.delete();
    obs_q.delete();
    $display("test_reset_mid_acc done");
  endtask

  initial begin
    test_reset();
    test_powerup();
    test_average();
    test_arbitration();
    test_req_during_acc();
    test_periodic();
    test_reset_mid_acc();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
